// File: rtl/acl_ctrl_pkg.sv
// rtl/acl_ctrl_pkg.sv - shared types and defaults for the ACL-gated FIFO read controller
package acl_ctrl_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int FIFO_AW_DEF  = 9;
   localparam int LQ_DEPTH_DEF = 4;
   localparam int LEN_W        = 10;

   // Frame length in words, 1..512
   typedef logic [LEN_W-1:0] len_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACL = 2'd1,
      ST_FWD      = 2'd2,
      ST_DROP     = 2'd3
   } state_t;

endpackage

// File: rtl/frame_len_fifo.sv
// rtl/frame_len_fifo.sv - small circular queue of completed frame lengths
module frame_len_fifo
   import acl_ctrl_pkg::*;
#(
   parameter int DEPTH = LQ_DEPTH_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  len_t push_len,
   input  logic pop,
   output len_t head_len,
   output logic full,
   output logic empty,
   output logic almost_full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   len_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A push into a full queue is dropped even if a pop happens the same cycle
   assign do_push     = push & ~full;
   assign do_pop      = pop & ~empty;
   assign full        = (count == CNT_W'(DEPTH));
   assign empty       = (count == '0);
   assign almost_full = (count >= CNT_W'(DEPTH - 1));
   assign head_len    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_len;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= bump(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - reads whole frames out of a data FIFO and forwards or drops each one on an ACL verdict
module fifo_rd_ctrl
   import acl_ctrl_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int FIFO_AW  = FIFO_AW_DEF,
   parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_wr_beat,
   input  logic               i_wr_tlast,
   input  logic [FIFO_AW-1:0] i_wr_cnt,
   output logic               o_rx_hold,
   output logic               o_rd_valid,
   input  logic [DATA_W-1:0]  i_fifo_data,
   input  logic               i_acl_valid,
   input  logic               i_acl_permit,
   output logic               o_acl_ready,
   output logic [DATA_W-1:0]  o_tx_tdata,
   output logic               o_tx_tvalid,
   output logic               o_tx_tlast,
   input  logic               i_tx_tready,
   output logic [15:0]        o_fwd_cnt,
   output logic [15:0]        o_drop_cnt
);

   localparam logic [FIFO_AW-1:0] HOLD_LVL = FIFO_AW'((1 << FIFO_AW) - 2);

   state_t            state;
   len_t              beat_cnt;
   len_t              frame_len;
   len_t              rd_left;
   logic              run_q;
   logic              acl_ready_q;
   logic              lq_push;
   logic              lq_pop;
   logic              lq_full;
   logic              lq_empty;
   logic              lq_afull;
   len_t              lq_head;
   logic              fwd_rd_d1;
   logic              last_d1;
   logic              sp_valid;
   logic              sp_last;
   logic [DATA_W-1:0] sp_data;
   logic              tx_pop;
   logic              rd_last;
   logic [1:0]        occ;

   assign frame_len = beat_cnt + len_t'(1);
   assign lq_push   = i_wr_beat & i_wr_tlast;
   assign lq_pop    = (state == ST_IDLE) & ~lq_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt <= '0;
      end else if (i_wr_beat) begin
         beat_cnt <= i_wr_tlast ? '0 : beat_cnt + len_t'(1);
      end
   end

   frame_len_fifo #(
      .DEPTH (LQ_DEPTH)
   ) u_len_q (
      .clk         (clk),
      .rst         (rst),
      .push        (lq_push),
      .push_len    (frame_len),
      .pop         (lq_pop),
      .head_len    (lq_head),
      .full        (lq_full),
      .empty       (lq_empty),
      .almost_full (lq_afull)
   );

   // run_q keeps hold low during reset even if the FIFO still reports a high level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

   assign o_rx_hold   = run_q & (lq_afull | lq_full | (i_wr_cnt >= HOLD_LVL));
   assign o_acl_ready = acl_ready_q;
   assign tx_pop      = o_tx_tvalid & i_tx_tready;

   // Skid occupancy after this cycle's egress pop, counting the read whose data lands now
   assign occ = {1'b0, o_tx_tvalid} + {1'b0, sp_valid} + {1'b0, fwd_rd_d1} - {1'b0, tx_pop};

   always_comb begin
      o_rd_valid = 1'b0;
      case (state)
         ST_FWD:  o_rd_valid = (rd_left != '0) && (occ < 2'd2);
         ST_DROP: o_rd_valid = (rd_left != '0);
         default: o_rd_valid = 1'b0;
      endcase
   end

   assign rd_last = o_rd_valid & (rd_left == len_t'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         rd_left     <= '0;
         acl_ready_q <= 1'b0;
         o_fwd_cnt   <= '0;
         o_drop_cnt  <= '0;
      end else begin
         if (o_rd_valid) begin
            rd_left <= rd_left - len_t'(1);
         end
         case (state)
            ST_IDLE: begin
               if (!lq_empty) begin
                  rd_left     <= lq_head;
                  acl_ready_q <= 1'b1;
                  state       <= ST_WAIT_ACL;
               end
            end
            ST_WAIT_ACL: begin
               if (i_acl_valid) begin
                  acl_ready_q <= 1'b0;
                  state       <= i_acl_permit ? ST_FWD : ST_DROP;
               end
            end
            ST_FWD: begin
               if (tx_pop && o_tx_tlast) begin
                  o_fwd_cnt <= o_fwd_cnt + 16'd1;
                  state     <= ST_IDLE;
               end
            end
            ST_DROP: begin
               if (rd_last) begin
                  o_drop_cnt <= o_drop_cnt + 16'd1;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Only forwarded reads are captured; dropped words returning late are ignored
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fwd_rd_d1   <= 1'b0;
         last_d1     <= 1'b0;
         sp_valid    <= 1'b0;
         sp_last     <= 1'b0;
         sp_data     <= '0;
         o_tx_tvalid <= 1'b0;
         o_tx_tlast  <= 1'b0;
         o_tx_tdata  <= '0;
      end else begin
         fwd_rd_d1 <= o_rd_valid & (state == ST_FWD);
         last_d1   <= rd_last;
         if (tx_pop) begin
            if (sp_valid) begin
               o_tx_tdata  <= sp_data;
               o_tx_tlast  <= sp_last;
               o_tx_tvalid <= 1'b1;
               sp_valid    <= fwd_rd_d1;
               sp_data     <= i_fifo_data;
               sp_last     <= last_d1;
            end else begin
               o_tx_tvalid <= fwd_rd_d1;
               o_tx_tlast  <= fwd_rd_d1 & last_d1;
               if (fwd_rd_d1) begin
                  o_tx_tdata <= i_fifo_data;
               end
            end
         end else if (fwd_rd_d1) begin
            if (!o_tx_tvalid) begin
               o_tx_tdata  <= i_fifo_data;
               o_tx_tlast  <= last_d1;
               o_tx_tvalid <= 1'b1;
            end else begin
               sp_data  <= i_fifo_data;
               sp_last  <= last_d1;
               sp_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;
   import acl_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        i_wr_beat;
   logic        i_wr_tlast;
   logic [8:0]  i_wr_cnt;
   logic        o_rx_hold;
   logic        o_rd_valid;
   logic [31:0] i_fifo_data;
   logic        i_acl_valid;
   logic        i_acl_permit;
   logic        o_acl_ready;
   logic [31:0] o_tx_tdata;
   logic        o_tx_tvalid;
   logic        o_tx_tlast;
   logic        i_tx_tready;
   logic [15:0] o_fwd_cnt;
   logic [15:0] o_drop_cnt;

   logic [31:0] wr_data;
   logic [31:0] fifo_q[$];
   logic [31:0] rx_data[$];
   logic        rx_last[$];
   int          rx_cyc[$];
   int          cyc;
   int          rd_count;
   int          tv_count;
   int          stall_err;
   logic        held;
   logic [31:0] hd;
   logic        hl;

   int checks;
   int errors;
   int base;
   int rd0;
   int tv0;

   fifo_rd_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .i_wr_beat    (i_wr_beat),
      .i_wr_tlast   (i_wr_tlast),
      .i_wr_cnt     (i_wr_cnt),
      .o_rx_hold    (o_rx_hold),
      .o_rd_valid   (o_rd_valid),
      .i_fifo_data  (i_fifo_data),
      .i_acl_valid  (i_acl_valid),
      .i_acl_permit (i_acl_permit),
      .o_acl_ready  (o_acl_ready),
      .o_tx_tdata   (o_tx_tdata),
      .o_tx_tvalid  (o_tx_tvalid),
      .o_tx_tlast   (o_tx_tlast),
      .i_tx_tready  (i_tx_tready),
      .o_fwd_cnt    (o_fwd_cnt),
      .o_drop_cnt   (o_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data FIFO model: one-cycle read latency, occupancy reported saturated at 511
   always @(posedge clk) begin
      if (!rst) begin
         fifo_q.delete();
         i_wr_cnt <= '0;
      end else begin
         if (o_rd_valid) begin
            if (fifo_q.size() > 0) i_fifo_data <= fifo_q.pop_front();
            else i_fifo_data <= 32'hDEAD_DEAD;
         end
         if (i_wr_beat) fifo_q.push_back(wr_data);
         i_wr_cnt <= (fifo_q.size() > 511) ? 9'd511 : 9'(fifo_q.size());
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         if (o_rd_valid) rd_count <= rd_count + 1;
         if (o_tx_tvalid) tv_count <= tv_count + 1;
         if (o_tx_tvalid && i_tx_tready) begin
            rx_data.push_back(o_tx_tdata);
            rx_last.push_back(o_tx_tlast);
            rx_cyc.push_back(cyc);
         end
         if (held && (!o_tx_tvalid || o_tx_tdata !== hd || o_tx_tlast !== hl))
            stall_err <= stall_err + 1;
         held <= o_tx_tvalid && !i_tx_tready;
         hd   <= o_tx_tdata;
         hl   <= o_tx_tlast;
      end else begin
         held <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_frame(input int len, input logic [31:0] fbase);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         i_wr_beat  = 1'b1;
         i_wr_tlast = (i == len - 1);
         wr_data    = fbase + 32'(i);
      end
   endtask

   task automatic wr_idle();
      @(negedge clk);
      i_wr_beat  = 1'b0;
      i_wr_tlast = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      for (int k = 0; k < budget && rx_data.size() < n; k++) @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input int start, input int len,
                              input logic [31:0] fbase);
      int bad;
      bad = 0;
      for (int i = 0; i < len; i++) begin
         if (start + i >= rx_data.size()) bad++;
         else if (rx_data[start+i] !== fbase + 32'(i) || rx_last[start+i] !== (i == len - 1)) bad++;
      end
      chk(tag, 64'(bad), 64'd0);
   endtask

   initial begin
      checks = 0; errors = 0;
      cyc = 0; rd_count = 0; tv_count = 0; stall_err = 0; held = 1'b0;
      hd = '0; hl = 1'b0; i_fifo_data = '0; i_wr_cnt = '0;
      rst = 1'b0; i_wr_beat = 1'b0; i_wr_tlast = 1'b0; wr_data = '0;
      i_acl_valid = 1'b0; i_acl_permit = 1'b0; i_tx_tready = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_rd_valid", 64'(o_rd_valid), 64'd0);
      chk("rst_tvalid", 64'(o_tx_tvalid), 64'd0);
      chk("rst_tlast", 64'(o_tx_tlast), 64'd0);
      chk("rst_tdata", 64'(o_tx_tdata), 64'd0);
      chk("rst_acl_ready", 64'(o_acl_ready), 64'd0);
      chk("rst_rx_hold", 64'(o_rx_hold), 64'd0);
      chk("rst_fwd_cnt", 64'(o_fwd_cnt), 64'd0);
      chk("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      i_tx_tready = 1'b1;

      // 16-word frame forwarded at full rate
      write_frame(16, 32'h1000_0000);
      wr_idle();
      @(negedge clk);
      chk("t1_acl_ready", 64'(o_acl_ready), 64'd1);
      chk("t1_no_rd_wait", 64'(o_rd_valid), 64'd0);
      base = rx_data.size();
      i_acl_valid = 1'b1; i_acl_permit = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_acl_valid = 1'b0;
      chk("t1_acl_ready_low", 64'(o_acl_ready), 64'd0);
      chk("t1_first_rd", 64'(o_rd_valid), 64'd1);
      chk("t1_tvalid_c0", 64'(o_tx_tvalid), 64'd0);
      @(negedge clk);
      chk("t1_tvalid_c1", 64'(o_tx_tvalid), 64'd0);
      @(negedge clk);
      chk("t1_tvalid_c2", 64'(o_tx_tvalid), 64'd1);
      chk("t1_tdata_c2", 64'(o_tx_tdata), 64'h1000_0000);
      wait_rx(base + 16, 60);
      chk("t1_beats", 64'(rx_data.size()), 64'(base + 16));
      check_frame("t1_frame", base, 16, 32'h1000_0000);
      chk("t1_back_to_back", 64'(rx_cyc[base+15] - rx_cyc[base]), 64'd15);
      repeat (2) @(negedge clk);
      chk("t1_fwd_cnt", 64'(o_fwd_cnt), 64'd1);

      // 10-word frame denied
      write_frame(10, 32'h2000_0000);
      wr_idle();
      @(negedge clk);
      chk("t2_acl_ready", 64'(o_acl_ready), 64'd1);
      rd0 = rd_count; tv0 = tv_count;
      i_acl_valid = 1'b1; i_acl_permit = 1'b0;
      @(posedge clk);
      @(negedge clk);
      i_acl_valid = 1'b0;
      chk("t2_first_rd", 64'(o_rd_valid), 64'd1);
      repeat (9) @(negedge clk);
      chk("t2_drop_cnt_early", 64'(o_drop_cnt), 64'd0);
      @(negedge clk);
      chk("t2_drop_cnt", 64'(o_drop_cnt), 64'd1);
      chk("t2_reads", 64'(rd_count - rd0), 64'd10);
      chk("t2_rd_done", 64'(o_rd_valid), 64'd0);
      repeat (3) @(negedge clk);
      chk("t2_no_tvalid", 64'(tv_count - tv0), 64'd0);

      // 8-word frame with egress ready toggling every cycle
      write_frame(8, 32'h3300_0000);
      wr_idle();
      @(negedge clk);
      chk("t3_acl_ready", 64'(o_acl_ready), 64'd1);
      rd0 = rd_count; base = rx_data.size();
      i_acl_valid = 1'b1; i_acl_permit = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 80 && rx_data.size() < base + 8; k++) begin
         @(negedge clk);
         i_acl_valid = 1'b0;
         i_tx_tready = ~i_tx_tready;
      end
      i_tx_tready = 1'b1;
      repeat (4) @(negedge clk);
      chk("t3_beats", 64'(rx_data.size()), 64'(base + 8));
      check_frame("t3_frame", base, 8, 32'h3300_0000);
      chk("t3_stall_stable", 64'(stall_err), 64'd0);
      chk("t3_reads", 64'(rd_count - rd0), 64'd8);
      chk("t3_fwd_cnt", 64'(o_fwd_cnt), 64'd2);

      // Length-queue backpressure: four 2-word frames with no verdict, then drop them
      for (int f = 0; f < 4; f++) begin
         write_frame(2, 32'h3000_0000 + 32'(16 * f));
         wr_idle();
         if (f == 2) chk("t4_hold_q2", 64'(o_rx_hold), 64'd0);
      end
      chk("t4_hold_q3", 64'(o_rx_hold), 64'd1);
      rd0 = rd_count; tv0 = tv_count;
      i_acl_valid = 1'b1; i_acl_permit = 1'b0;
      repeat (40) @(negedge clk);
      i_acl_valid = 1'b0;
      chk("t4_drop_cnt", 64'(o_drop_cnt), 64'd5);
      chk("t4_reads", 64'(rd_count - rd0), 64'd8);
      chk("t4_no_tvalid", 64'(tv_count - tv0), 64'd0);
      chk("t4_hold_clear", 64'(o_rx_hold), 64'd0);

      // Back-to-back 1 / 512 / 5 word frames with the verdict held off
      write_frame(1, 32'h4000_0000);
      write_frame(512, 32'h5000_0000);
      write_frame(5, 32'h6000_0000);
      wr_idle();
      chk("t5_hold", 64'(o_rx_hold), 64'd1);
      base = rx_data.size();
      i_acl_valid = 1'b1; i_acl_permit = 1'b1;
      wait_rx(base + 518, 1500);
      i_acl_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_beats", 64'(rx_data.size()), 64'(base + 518));
      check_frame("t5_len1", base, 1, 32'h4000_0000);
      check_frame("t5_len512", base + 1, 512, 32'h5000_0000);
      check_frame("t5_len5", base + 513, 5, 32'h6000_0000);
      chk("t5_fwd_cnt", 64'(o_fwd_cnt), 64'd5);
      chk("t5_hold_clear", 64'(o_rx_hold), 64'd0);

      // Reset during forwarding of a 12-word frame, after word 4
      write_frame(12, 32'h7000_0000);
      wr_idle();
      base = rx_data.size();
      i_acl_valid = 1'b1; i_acl_permit = 1'b1;
      wait_rx(base + 4, 40);
      i_acl_valid = 1'b0;
      chk("t6_word4", 64'(rx_data.size()), 64'(base + 4));
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rd_valid", 64'(o_rd_valid), 64'd0);
      chk("t6_tvalid", 64'(o_tx_tvalid), 64'd0);
      chk("t6_tlast", 64'(o_tx_tlast), 64'd0);
      chk("t6_tdata", 64'(o_tx_tdata), 64'd0);
      chk("t6_acl_ready", 64'(o_acl_ready), 64'd0);
      chk("t6_rx_hold", 64'(o_rx_hold), 64'd0);
      chk("t6_fwd_cnt", 64'(o_fwd_cnt), 64'd0);
      chk("t6_drop_cnt", 64'(o_drop_cnt), 64'd0);
      chk("t6_state", 64'(dut.state), 64'(ST_IDLE));
      @(negedge clk);
      rst = 1'b1;
      rd0 = rd_count;
      repeat (20) @(negedge clk);
      chk("t6_no_reads", 64'(rd_count - rd0), 64'd0);
      chk("t6_no_beats", 64'(rx_data.size()), 64'(base + 4));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have params: DATA_W 32, data word width; FIFO_AW 9, FIFO address width (depth 512); LQ_DEPTH 4, frame-length queue entries.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_wr_beat  in  1  one word accepted into FIFO (tvalid & tready) this cycle.
- i_wr_tlast  in  1  accepted word is last of frame; qualified by i_wr_beat.
- i_wr_cnt  in  FIFO_AW  FIFO occupancy in words.
- o_rx_hold  out  1  backpressure request to FIFO write side.
- o_rd_valid  out  1  FIFO read enable, one word per asserted cycle.
- i_fifo_data  in  DATA_W  FIFO read data, valid 1 cycle after o_rd_valid.
- i_acl_valid  in  1  ACL verdict valid.
- i_acl_permit  in  1  1 = forward frame, 0 = drop frame.
- o_acl_ready  out  1  verdict accepted when i_acl_valid & o_acl_ready.
- o_tx_tdata  out  DATA_W  egress AXI-Stream data.
- o_tx_tvalid  out  1  egress valid.
- o_tx_tlast  out  1  egress last word of frame.
- i_tx_tready  in  1  egress ready.
- o_fwd_cnt  out  16  forwarded-frame count, wraps.
- o_drop_cnt  out  16  dropped-frame count, wraps.

Function
REQ-003 SHALL count write beats per frame in a 10-bit counter; on i_wr_beat & i_wr_tlast, push count+1 (range 1..512) into length queue, clear counter.
REQ-004 SHALL assert o_rx_hold while length queue holds LQ_DEPTH-1 or more entries, or i_wr_cnt >= 2^FIFO_AW - 2.
REQ-005 SHALL implement FSM IDLE, WAIT_ACL, FWD, DROP.
REQ-006 IDLE -> WAIT_ACL when length queue non-empty; latch head length into rd_left, pop queue.
REQ-007 WAIT_ACL: o_acl_ready=1; on handshake go to FWD if i_acl_permit=1, else DROP; no other state asserts o_acl_ready.
REQ-008 FWD: o_rd_valid=1 when rd_left>0 and (buffered words + reads in flight) < 2; each read decrements rd_left.
REQ-009 FWD SHALL hold returned words in a 2-entry skid buffer driving o_tx_*; o_tx_tdata/o_tx_tlast SHALL stay stable while o_tx_tvalid & !i_tx_tready.
REQ-010 o_tx_tlast SHALL be 1 only on the word that is the frame's final FIFO read.
REQ-011 FWD -> IDLE on the cycle the tlast word handshakes; o_fwd_cnt += 1 that cycle.
REQ-012 DROP: o_rd_valid=1 every cycle while rd_left>0, data discarded, o_tx_tvalid=0; -> IDLE after last read issued; o_drop_cnt += 1 that cycle.
REQ-013 Sustained FWD throughput SHALL be 1 word/cycle with i_tx_tready=1; first word on o_tx after 2 cycles from FWD entry.
REQ-014 Push and pop of the length queue in the same cycle SHALL both take effect; push into full queue SHALL be ignored (prevented by REQ-004).
REQ-015 1-word frame SHALL produce single beat with o_tx_tlast=1.
REQ-016 o_rd_valid SHALL never be asserted in IDLE or WAIT_ACL.

Reset
REQ-017 While rst=0: FSM=IDLE, queue empty, beat counter=0, rd_left=0, skid buffer empty, o_rd_valid=0, o_tx_tvalid=0, o_tx_tlast=0, o_tx_tdata=0, o_acl_ready=0, o_rx_hold=0, o_fwd_cnt=0, o_drop_cnt=0.
REQ-018 Reset mid-frame SHALL abandon the frame with no further o_tx beats; FIFO flush is the FIFO's own responsibility.

Structure
REQ-019 Package acl_ctrl_pkg SHALL hold FSM state enum, DATA_W/FIFO_AW defaults, length type (10-bit).
REQ-020 Length queue SHALL be a sub-module frame_len_fifo (LQ_DEPTH x 10-bit, push/pop/full/empty/almost_full).

Verification
REQ-021 Write 16-word frame, verdict permit, i_tx_tready=1 -> 16 consecutive o_tx beats, tlast on 16th, o_fwd_cnt=1.
REQ-022 Write 10-word frame, verdict deny -> 10 o_rd_valid cycles, o_tx_tvalid never 1, o_drop_cnt=1.
REQ-023 Permit 8-word frame, i_tx_tready toggling 1/0 each cycle -> 8 beats, data in order, stable while stalled, no extra reads.
REQ-024 Write 3 back-to-back frames (1, 512, 5 words) with verdict held off -> o_rx_hold=1 after 3rd tlast; then permit all -> lengths 1/512/5 with correct tlast.
REQ-025 Assert rst=0 mid-FWD on word 4 of 12 -> all outputs at reset values next edge, FSM IDLE, counters 0.
